// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the dmem_lsu data memory slice.
//   * RV32I load/store funct3 encodings
//   * controller state encoding (CLEAR walk / RUN)
//   * word/half/byte widths used by the storage and the load formatter
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = WORD_W / BYTE_W;

endpackage : dmem_pkg

// File: rtl/dmem_ram_be.sv
// dmem_ram_be -- DEPTH x 32-bit single-port storage with per-byte write
// enables and a registered read port (data appears the cycle after re_i).
// Contents are not reset; the owning controller zeroes them with a walk.
// Ports:
//   clk_i    clock
//   we_i     write strobe, bytes selected by be_i
//   be_i     byte-lane enables (lane 0 = bits 7:0)
//   addr_i   word index shared by read and write
//   wdata_i  write data, already placed in its lanes
//   re_i     read strobe; rdata_o holds its value otherwise
//   rdata_o  registered read word
module dmem_ram_be
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 3072,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [LANES-1:0]  be_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : dmem_ram_be

// File: rtl/dmem_lsu.sv
// dmem_lsu -- RV32I data memory with request/response handshake.
// After reset a hardware walk zeroes every word (DEPTH cycles, req_ready=0),
// then one load/store is accepted per cycle with the response one cycle later.
// Sub-word stores use byte enables; loads are formatted (sign/zero extend)
// from the registered read word. Out-of-range, illegal funct3 and (when
// enabled) misaligned accesses return resp_err=1 with no write and rdata=0.
// Build option:
//   DMEM_MISALIGN_TRAP_EN  defined   : misaligned half/word accesses fault
//                          undefined : low address bits are ignored for
//                                      alignment (half uses lane[1] only)
// Ports:
//   clk, rst_n (async, active-low)
//   req_valid/req_ready handshake; req_we, req_funct3, req_addr, req_wdata
//   resp_valid (1-cycle pulse), resp_rdata, resp_err
//   init_done  clear walk finished
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 3072,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_done
);

  localparam logic [31:0]      DEPTH_W  = 32'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // Sign/zero extension of the selected byte or half of a loaded word.
  function automatic logic [WORD_W-1:0] load_format(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        lane,
    input logic [2:0]        f3
  );
    logic [BYTE_W-1:0] b;
    logic [HALF_W-1:0] h;
    logic [WORD_W-1:0] r;
    b = word[{lane, 3'b000} +: BYTE_W];
    h = lane[1] ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];
    case (f3)
      F3_B:    r = {{(WORD_W-BYTE_W){b[BYTE_W-1]}}, b};
      F3_BU:   r = {{(WORD_W-BYTE_W){1'b0}}, b};
      F3_H:    r = {{(WORD_W-HALF_W){h[HALF_W-1]}}, h};
      F3_HU:   r = {{(WORD_W-HALF_W){1'b0}}, h};
      F3_W:    r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_e           state_q;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             req_ready_q, init_done_q;
  logic             resp_valid_q, resp_err_q, ld_q;
  logic [1:0]       lane_q;
  logic [2:0]       f3_q;

  logic [31:0]       off;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              in_range;
  logic              f3_ok;
  logic              misalign;
  logic              err;
  logic [LANES-1:0]  st_be;
  logic [WORD_W-1:0] st_data;
  logic              accept, wr_fire, rd_fire;

  logic              ram_we, ram_re;
  logic [LANES-1:0]  ram_be;
  logic [IDX_W-1:0]  ram_addr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;

  assign off      = req_addr - BASE_ADDR;
  assign idx      = off[IDX_W+1:2];
  assign lane     = off[1:0];
  // Addresses below BASE_ADDR wrap to a huge offset and land here too.
  assign in_range = ({2'b00, off[31:2]} < DEPTH_W);

  // funct3 legality and store lane placement.
  always_comb begin
    f3_ok   = 1'b0;
    st_be   = '0;
    st_data = '0;
    case (req_funct3)
      F3_B: begin
        f3_ok   = 1'b1;
        st_be   = LANES'(1) << lane;
        st_data = {LANES{req_wdata[BYTE_W-1:0]}};
      end
      F3_H: begin
        f3_ok   = 1'b1;
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[HALF_W-1:0]}};
      end
      F3_W: begin
        f3_ok   = 1'b1;
        st_be   = '1;
        st_data = req_wdata;
      end
      F3_BU, F3_HU: f3_ok = !req_we;
      default:      f3_ok = 1'b0;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: misalign = lane[0];
      F3_W:        misalign = (lane != 2'b00);
      default:     misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign err     = !in_range || !f3_ok || misalign;
  assign accept  = req_valid && req_ready_q;
  assign wr_fire = accept &&  req_we && !err;
  assign rd_fire = accept && !req_we && !err;

  // The clear walk owns the RAM port; no request can be accepted meanwhile.
  always_comb begin
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_be    = '1;
      ram_addr  = clr_idx_q;
      ram_wdata = '0;
    end else begin
      ram_we    = wr_fire;
      ram_be    = st_be;
      ram_addr  = idx;
      ram_wdata = st_data;
    end
  end
  assign ram_re = rd_fire;

  assign clr_idx_d = clr_idx_q + IDX_W'(1);

  // Control FSM and response flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      clr_idx_q    <= '0;
      req_ready_q  <= 1'b0;
      init_done_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      ld_q         <= 1'b0;
    end else begin
      resp_valid_q <= accept;
      resp_err_q   <= accept && err;
      ld_q         <= rd_fire;
      case (state_q)
        ST_CLEAR: begin
          if (clr_idx_q == LAST_IDX) begin
            state_q     <= ST_RUN;
            req_ready_q <= 1'b1;
            init_done_q <= 1'b1;
          end else begin
            clr_idx_q   <= clr_idx_d;
          end
        end
        ST_RUN: req_ready_q <= 1'b1;
      endcase
    end
  end

  // Load selection context travels with the registered read word.
  always_ff @(posedge clk) begin
    if (accept) begin
      lane_q <= lane;
      f3_q   <= req_funct3;
    end
  end

  dmem_ram_be #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

  assign req_ready  = req_ready_q;
  assign init_done  = init_done_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = (resp_valid_q && ld_q) ? load_format(ram_rdata, lane_q, f3_q) : '0;

endmodule : dmem_lsu

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu -- randomized bench for dmem_lsu against a byte-level memory model.
module tb_dmem_lsu;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_addr = BASE;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_done;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mdl [DEPTH];

  dmem_lsu #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 32'h0;
  endtask

  // Reference behaviour: returns expected err/rdata and applies stores.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic e_err, output logic [31:0] e_rd);
    logic [31:0] off, widx, w, v;
    int lane, size;
    bit legal, mis;
    off  = addr - BASE;
    widx = off / 4;
    lane = int'(off % 4);
    size = int'(f3 % 4);
    legal = we ? (f3 == 0 || f3 == 1 || f3 == 2)
               : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    mis = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (size == 1 && lane % 2 == 1) || (size == 2 && lane != 0);
`endif
    e_err = (widx >= DEPTH) || !legal || mis;
    e_rd  = 32'h0;
    if (!e_err) begin
      w = mdl[widx];
      if (we) begin
        for (int k = 0; k < 4; k++) begin
          bit hit;
          logic [7:0] src;
          hit = (size == 0) ? (k == lane) : (size == 1) ? (k / 2 == lane / 2) : 1'b1;
          src = (size == 0) ? wd[7:0] : (size == 1) ? wd[8*(k%2) +: 8] : wd[8*k +: 8];
          if (hit) w[8*k +: 8] = src;
        end
        mdl[widx] = w;
      end else begin
        if (size == 0) begin
          v = (w >> (8 * lane)) & 32'hFF;
          if (f3 == 0 && v >= 32'h80) v = v - 32'h100;
        end else if (size == 1) begin
          v = (w >> (16 * (lane / 2))) & 32'hFFFF;
          if (f3 == 1 && v >= 32'h8000) v = v - 32'h10000;
        end else begin
          v = w;
        end
        e_rd = v;
      end
    end
  endtask

  // One accepted request; response is sampled just after the accept edge.
  task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
    logic        e_err;
    logic [31:0] e_rd;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    model(we, f3, addr, wd, e_err, e_rd);
    chk({tag, ".valid"}, 32'(resp_valid), 32'h1);
    chk({tag, ".err"},   32'(resp_err),   32'(e_err));
    chk({tag, ".rdata"}, resp_rdata,      e_rd);
    rd = resp_rdata;
    er = resp_err;
  endtask

  task automatic idle(input string tag);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".idle"}, 32'(resp_valid), 32'h0);
  endtask

  // Holds a request during the walk; it must be ignored for DEPTH cycles.
  task automatic wait_init(input string tag);
    int n, bad;
    n = 0;
    bad = 0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = BASE + 32'h8;
    req_wdata  = 32'hDEAD_BEEF;
    while (req_ready !== 1'b1 && n < int'(DEPTH) + 8) begin
      @(posedge clk);
      #1;
      n++;
      if (resp_valid !== 1'b0) bad++;
      if (init_done !== req_ready) bad++;
    end
    req_valid = 1'b0;
    chk({tag, ".clear_len"}, 32'(n), 32'(DEPTH));
    chk({tag, ".clear_quiet"}, 32'(bad), 32'h0);
    chk({tag, ".init_done"}, 32'(init_done), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [2:0]  f3;
    logic [31:0] a;
    int          sel;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("rst.ready",  32'(req_ready),  32'h0);
    chk("rst.valid",  32'(resp_valid), 32'h0);
    chk("rst.rdata",  resp_rdata,      32'h0);
    chk("rst.err",    32'(resp_err),   32'h0);
    chk("rst.init",   32'(init_done),  32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset in the middle of the walk restarts it from word 0.
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midclr.ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_zero();
    wait_init("init1");

    xfer("lw0", 1'b0, 3'b010, BASE + 4 * 32'($urandom_range(DEPTH - 1)), 32'h0, rd, er);
    chk("lw0.zero", rd, 32'h0);
    idle("i0");

    // Sign/zero extension of bytes.
    xfer("sw10", 1'b1, 3'b010, BASE + 32'h10, 32'h8000_00FF, rd, er);
    xfer("lb10", 1'b0, 3'b000, BASE + 32'h10, 32'h0, rd, er);
    chk("lb10.const", rd, 32'hFFFF_FFFF);
    xfer("lbu10", 1'b0, 3'b100, BASE + 32'h10, 32'h0, rd, er);
    chk("lbu10.const", rd, 32'h0000_00FF);
    xfer("lb13", 1'b0, 3'b000, BASE + 32'h13, 32'h0, rd, er);
    chk("lb13.const", rd, 32'hFFFF_FF80);
    idle("i1");

    // Byte-lane merging, back-to-back.
    xfer("sw20", 1'b1, 3'b010, BASE + 32'h20, 32'h1122_3344, rd, er);
    xfer("sb21", 1'b1, 3'b000, BASE + 32'h21, 32'h0000_00AA, rd, er);
    xfer("sh22", 1'b1, 3'b001, BASE + 32'h22, 32'h0000_BEEF, rd, er);
    xfer("lw20", 1'b0, 3'b010, BASE + 32'h20, 32'h0, rd, er);
    chk("lw20.const", rd, 32'hBEEF_AA44);
    xfer("lh21", 1'b0, 3'b001, BASE + 32'h21, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lh21.const", {rd[30:0], er}, 32'h1);
`else
    chk("lh21.const", {rd[30:0], er}, {32'hFFFF_AA44 << 1});
`endif
    idle("i2");

    // Faulting stores leave memory untouched.
    xfer("sw_oor", 1'b1, 3'b010, BASE + 4 * DEPTH, 32'hCAFE_F00D, rd, er);
    chk("sw_oor.errc", 32'(er), 32'h1);
    xfer("sw_below", 1'b1, 3'b010, BASE - 32'h4, 32'hCAFE_F00D, rd, er);
    xfer("s011", 1'b1, 3'b011, BASE + 32'h20, 32'hCAFE_F00D, rd, er);
    chk("s011.errc", 32'(er), 32'h1);
    xfer("lw20b", 1'b0, 3'b010, BASE + 32'h20, 32'h0, rd, er);
    chk("lw20b.const", rd, 32'hBEEF_AA44);
    xfer("lwbase", 1'b0, 3'b010, BASE, 32'h0, rd, er);
    chk("lwbase.const", rd, 32'h0);
    xfer("lw_last", 1'b0, 3'b010, BASE + 4 * (DEPTH - 1), 32'h0, rd, er);
    idle("i3");

    // Randomized traffic with idle gaps.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        idle("rnd");
      end else begin
        sel = int'($urandom_range(7));
        if (sel < 6) f3 = (sel < 2) ? 3'b010 : (sel < 3) ? 3'b000 : (sel < 4) ? 3'b001 :
                          (sel < 5) ? 3'b100 : 3'b101;
        else         f3 = 3'($urandom_range(7));
        sel = int'($urandom_range(15));
        if (sel == 0)      a = BASE + 4 * DEPTH + $urandom_range(63);
        else if (sel == 1) a = BASE - 1 - $urandom_range(15);
        else               a = BASE + $urandom_range(4 * DEPTH - 1);
        xfer("rnd", 1'($urandom_range(1)), f3, a, $urandom, rd, er);
      end
    end
    idle("i4");

    // Reset right after a load accept drops its response and re-zeroes RAM.
    xfer("sw40", 1'b1, 3'b010, BASE + 32'h40, 32'h1234_5678, rd, er);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = BASE + 32'h40;
    @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rstld.valid", 32'(resp_valid), 32'h0);
    chk("rstld.ready", 32'(req_ready),  32'h0);
    chk("rstld.init",  32'(init_done),  32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_zero();
    wait_init("init2");
    xfer("lw40", 1'b0, 3'b010, BASE + 32'h40, 32'h0, rd, er);
    chk("lw40.const", rd, 32'h0);
    idle("i5");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule : tb_dmem_lsu
